// File: rtl/stage0_drv_pkg.sv
// Shared types and default parameters for the stage0 flush/fence driver.
package stage0_drv_pkg;

  localparam int DRV_XLEN    = 64;
  localparam int DRV_DEPTH   = 4;
  localparam int DRV_DELAYW  = 8;
  localparam int DRV_TIMEOUT = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_DRIVE,
    ST_FENCE_WAIT
  } drv_state_e;

  typedef struct packed {
    logic [DRV_XLEN-1:0]   pc;
    logic                  fence;
    logic                  sfence;
    logic [DRV_DELAYW-1:0] delay;
  } drv_cmd_t;

endpackage

// File: rtl/stage0_drv_fifo.sv
// Command FIFO with a registered head stage: entries land in an array with a
// registered read, so a pushed command is visible at the head one cycle later.
module stage0_drv_fifo
  import stage0_drv_pkg::*;
#(
  parameter int  DEPTH = DRV_DEPTH,
  parameter type T     = drv_cmd_t
) (
  input  logic clk,
  input  logic srst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full,
  output logic occupied
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  T                head_reg;
  logic            head_valid_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   mem_count_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;
  logic            load;

  assign do_push = push && !full;
  assign do_pop  = pop && head_valid_reg;
  // Refill the head from the array whenever it is empty or being consumed.
  assign load    = (mem_count_reg != '0) && (!head_valid_reg || do_pop);

  assign head     = head_reg;
  assign empty    = !head_valid_reg;
  assign full     = (count_reg == CW'(DEPTH));
  assign occupied = (count_reg != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
    if (load) begin
      head_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      mem_count_reg <= mem_count_reg + CW'(do_push) - CW'(load);
      count_reg     <= count_reg + CW'(do_push) - CW'(do_pop);
      if (load) begin
        head_valid_reg <= 1'b1;
      end else if (do_pop) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage0_flush_driver.sv
// Scripted redirect/flush driver for the fetch stage with an expected-epoch model.
// Define STAGE0_DRV_TIMEOUT_EN to build the fence-wait watchdog (err_timeout).
module stage0_flush_driver
  import stage0_drv_pkg::*;
#(
  parameter int XLEN    = DRV_XLEN,
  parameter int DEPTH   = DRV_DEPTH,
  parameter int DELAYW  = DRV_DELAYW,
  parameter int TIMEOUT = DRV_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XLEN-1:0]   cmd_pc,
  input  logic              cmd_fence,
  input  logic              cmd_sfence,
  input  logic [DELAYW-1:0] cmd_delay,
  output logic              flush_en,
  input  logic              flush_rdy,
  output logic [XLEN-1:0]   flush_pc,
  output logic              flush_fence,
  output logic              flush_sfence,
  input  logic              fence_done,
  output logic              exp_eepoch,
  output logic              busy,
  output logic [15:0]       flush_count,
  output logic              err_timeout
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              fence;
    logic              sfence;
    logic [DELAYW-1:0] delay;
  } cmd_t;

  cmd_t              cmd_in;
  cmd_t              head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_occupied;
  logic              pop;
  logic              xfer;

  drv_state_e        state_reg, state_next;
  logic [DELAYW-1:0] delay_reg, delay_next;
  logic [XLEN-1:0]   work_pc_reg;
  logic              work_fence_reg;
  logic              work_sfence_reg;
  logic              eepoch_reg;
  logic [15:0]       count_reg;

  assign cmd_in = '{pc: cmd_pc, fence: cmd_fence, sfence: cmd_sfence, delay: cmd_delay};

  stage0_drv_fifo #(
    .DEPTH(DEPTH),
    .T    (cmd_t)
  ) u_fifo (
    .clk      (CLK),
    .srst     (RST),
    .push     (cmd_valid),
    .push_data(cmd_in),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .occupied (fifo_occupied)
  );

`ifdef STAGE0_DRV_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt_reg;
  logic          err_timeout_reg;
  logic          timeout_hit;
`endif

  always_comb begin
    state_next = state_reg;
    delay_next = delay_reg;
    pop        = 1'b0;
    xfer       = 1'b0;
`ifdef STAGE0_DRV_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.delay != '0) begin
            state_next = ST_DELAY;
            delay_next = head.delay - DELAYW'(1);
          end else begin
            state_next = ST_DRIVE;
          end
        end
      end
      ST_DELAY: begin
        if (delay_reg == '0) begin
          state_next = ST_DRIVE;
        end else begin
          delay_next = delay_reg - DELAYW'(1);
        end
      end
      ST_DRIVE: begin
        if (flush_rdy) begin
          xfer       = 1'b1;
          state_next = (work_fence_reg || work_sfence_reg) ? ST_FENCE_WAIT : ST_IDLE;
        end
      end
      ST_FENCE_WAIT: begin
        // A completion on the limit cycle wins over the watchdog.
        if (fence_done) begin
          state_next = ST_IDLE;
        end
`ifdef STAGE0_DRV_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      delay_reg       <= '0;
      work_pc_reg     <= '0;
      work_fence_reg  <= 1'b0;
      work_sfence_reg <= 1'b0;
      eepoch_reg      <= 1'b0;
      count_reg       <= '0;
    end else begin
      state_reg <= state_next;
      delay_reg <= delay_next;
      if (pop) begin
        // A command flagged both ways is handled purely as a fence.i.
        work_pc_reg     <= head.pc;
        work_fence_reg  <= head.fence;
        work_sfence_reg <= head.sfence & ~head.fence;
      end
      if (xfer) begin
        eepoch_reg <= ~eepoch_reg;
        count_reg  <= count_reg + 16'd1;
      end
    end
  end

`ifdef STAGE0_DRV_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == ST_FENCE_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_hit) begin
        err_timeout_reg <= 1'b1;
      end
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  // Without the watchdog TIMEOUT has no effect and the flag is constant low.
  assign err_timeout = 1'b0 & (TIMEOUT > 0);
`endif

  assign flush_en     = (state_reg == ST_DRIVE);
  assign flush_pc     = flush_en ? work_pc_reg : '0;
  assign flush_fence  = flush_en & work_fence_reg;
  assign flush_sfence = flush_en & work_sfence_reg;
  assign cmd_ready    = !fifo_full;
  assign busy         = (state_reg != ST_IDLE) || fifo_occupied;
  assign exp_eepoch   = eepoch_reg;
  assign flush_count  = count_reg;

endmodule

// File: tb/tb_stage0_flush_driver.sv
// Directed bench for stage0_flush_driver: vector table of single redirects plus
// hand-written sequences for backpressure, fence wait, watchdog and reset.
module tb_stage0_flush_driver;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_pc;
  logic        cmd_fence;
  logic        cmd_sfence;
  logic [7:0]  cmd_delay;
  logic        flush_en;
  logic        flush_rdy;
  logic [63:0] flush_pc;
  logic        flush_fence;
  logic        flush_sfence;
  logic        fence_done;
  logic        exp_eepoch;
  logic        busy;
  logic [15:0] flush_count;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  stage0_flush_driver #(
    .XLEN   (64),
    .DEPTH  (4),
    .DELAYW (8),
    .TIMEOUT(16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_pc      (cmd_pc),
    .cmd_fence   (cmd_fence),
    .cmd_sfence  (cmd_sfence),
    .cmd_delay   (cmd_delay),
    .flush_en    (flush_en),
    .flush_rdy   (flush_rdy),
    .flush_pc    (flush_pc),
    .flush_fence (flush_fence),
    .flush_sfence(flush_sfence),
    .fence_done  (fence_done),
    .exp_eepoch  (exp_eepoch),
    .busy        (busy),
    .flush_count (flush_count),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic [63:0] pc;
    logic        fence;
    logic        sfence;
    int          delay;
    int          rdy_low;
    int          done_wait;
    int          exp_lat;
    int          exp_en;
    logic        exp_f;
    logic        exp_s;
    int          exp_count;
    logic        exp_ep;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic f, input logic s, input logic [7:0] d);
    cmd_valid  = 1'b1;
    cmd_pc     = pc;
    cmd_fence  = f;
    cmd_sfence = s;
    cmd_delay  = d;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_en(input int lim);
    int n;
    n = 0;
    while (!flush_en && n < lim) begin
      tick();
      n++;
    end
  endtask

  // Push one delay-0 redirect with flush_rdy high and let it transfer.
  task automatic drive_one(input string name, input logic [63:0] pc);
    flush_rdy = 1'b1;
    push(pc, 1'b0, 1'b0, 8'd0);
    wait_en(20);
    check({name, "_en"}, 64'(flush_en), 64'd1);
    check({name, "_pc"}, flush_pc, pc);
    tick();
    flush_rdy = 1'b0;
  endtask

  initial begin
    vec_t        v;
    int          lat;
    int          en;
    logic        stable;
    logic [63:0] pc0;
    logic [63:0] seq_pc[5];
    int          acc;
    int          edges;
    int          got;
    int          cyc;
    int          last_cyc;
    logic        order_ok;
    logic        gap_ok;
    logic        quiet_ok;

    //            pc                      f     s     dly  rl dw lat en  ef    es    cnt ep
    vecs[0] = '{64'h0000_0000_8000_0040, 1'b0, 1'b0, 0,   0, 0, 2,   1, 1'b0, 1'b0, 1, 1'b1};
    vecs[1] = '{64'h1234_5678_9abc_def0, 1'b0, 1'b0, 5,   3, 0, 7,   4, 1'b0, 1'b0, 2, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_1000, 1'b1, 1'b0, 1,   0, 3, 3,   1, 1'b1, 1'b0, 3, 1'b1};
    vecs[3] = '{64'hffff_ffff_ffff_fffc, 1'b0, 1'b1, 0,   1, 0, 2,   2, 1'b0, 1'b1, 4, 1'b0};
    vecs[4] = '{64'h0000_0000_2000_0008, 1'b1, 1'b1, 2,   0, 2, 4,   1, 1'b1, 1'b0, 5, 1'b1};
    vecs[5] = '{64'h0000_0000_0000_0004, 1'b0, 1'b0, 255, 0, 0, 257, 1, 1'b0, 1'b0, 6, 1'b0};

    RST        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_pc     = '0;
    cmd_fence  = 1'b0;
    cmd_sfence = 1'b0;
    cmd_delay  = '0;
    flush_rdy  = 1'b0;
    fence_done = 1'b0;
    repeat (3) tick();

    check("rst_flush_en", 64'(flush_en), 64'd0);
    check("rst_flush_pc", flush_pc, 64'd0);
    check("rst_flush_flags", 64'({flush_fence, flush_sfence}), 64'd0);
    check("rst_eepoch", 64'(exp_eepoch), 64'd0);
    check("rst_count", 64'(flush_count), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    RST = 1'b0;
    tick();

    // Single redirects from an idle driver.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      push(v.pc, v.fence, v.sfence, 8'(v.delay));
      lat = 0;
      while (!flush_en && lat < 400) begin
        tick();
        lat++;
      end
      check($sformatf("row%0d_latency", i), 64'(lat), 64'(v.exp_lat));
      pc0 = flush_pc;
      check($sformatf("row%0d_pc", i), pc0, v.pc);
      check($sformatf("row%0d_fence", i), 64'(flush_fence), 64'(v.exp_f));
      check($sformatf("row%0d_sfence", i), 64'(flush_sfence), 64'(v.exp_s));
      en = 0;
      stable = 1'b1;
      while (flush_en && en < 50) begin
        en++;
        if (flush_pc !== pc0) stable = 1'b0;
        flush_rdy = (en > v.rdy_low);
        tick();
      end
      flush_rdy = 1'b0;
      check($sformatf("row%0d_en_cycles", i), 64'(en), 64'(v.exp_en));
      check($sformatf("row%0d_pc_stable", i), 64'(stable), 64'd1);
      check($sformatf("row%0d_count", i), 64'(flush_count), 64'(v.exp_count));
      check($sformatf("row%0d_eepoch", i), 64'(exp_eepoch), 64'(v.exp_ep));
      if (v.fence || v.sfence) begin
        check($sformatf("row%0d_fence_wait_busy", i), 64'({busy, flush_en}), 64'b10);
        repeat (v.done_wait) tick();
        fence_done = 1'b1;
        tick();
        fence_done = 1'b0;
      end
      check($sformatf("row%0d_idle", i), 64'(busy), 64'd0);
      $display("row %0d: pc=0x%0h delay=%0d latency=%0d en_cycles=%0d count=%0d eepoch=%0d",
               i, v.pc, v.delay, lat, en, flush_count, exp_eepoch);
    end

    // Five pushes against a stalled FSM: first is popped, four fill the FIFO.
    for (int i = 0; i < 5; i++) seq_pc[i] = 64'h100 * 64'(i + 1);
    flush_rdy = 1'b0;
    acc = 0;
    edges = 0;
    while (acc < 5 && edges < 20) begin
      logic was_ready;
      cmd_valid  = 1'b1;
      cmd_pc     = seq_pc[acc];
      cmd_fence  = 1'b0;
      cmd_sfence = 1'b0;
      cmd_delay  = 8'd0;
      was_ready  = cmd_ready;
      tick();
      edges++;
      if (was_ready) acc++;
    end
    cmd_valid = 1'b0;
    check("fill_edges", 64'(edges), 64'd5);
    check("fill_ready_low", 64'(cmd_ready), 64'd0);
    check("fill_driving_first", flush_pc, seq_pc[0]);
    $display("fill: accepted=%0d in %0d edges cmd_ready=%0d", acc, edges, cmd_ready);

    flush_rdy = 1'b1;
    got = 0;
    cyc = 0;
    last_cyc = 0;
    order_ok = 1'b1;
    gap_ok = 1'b1;
    while (got < 5 && cyc < 60) begin
      if (flush_en) begin
        if (flush_pc !== seq_pc[got]) order_ok = 1'b0;
        if (got > 0 && (cyc - last_cyc) != 2) gap_ok = 1'b0;
        $display("drain: flush %0d pc=0x%0h cycle=%0d", got, flush_pc, cyc);
        last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    flush_rdy = 1'b0;
    check("drain_flushes", 64'(got), 64'd5);
    check("drain_order", 64'(order_ok), 64'd1);
    check("drain_spacing", 64'(gap_ok), 64'd1);
    check("drain_count", 64'(flush_count), 64'd11);
    check("drain_eepoch", 64'(exp_eepoch), 64'd1);
    check("drain_ready", 64'(cmd_ready), 64'd1);
    check("drain_idle", 64'(busy), 64'd0);

    // Fence with a follow-up queued behind it; completion 10 cycles after acceptance.
    flush_rdy = 1'b1;
    push(64'h0000_0000_8000_1000, 1'b1, 1'b0, 8'd0);
    push(64'h0000_0000_8000_2000, 1'b0, 1'b0, 8'd0);
    wait_en(20);
    check("fence_seq_pc", flush_pc, 64'h0000_0000_8000_1000);
    tick();
    quiet_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (flush_en !== 1'b0 || flush_pc !== 64'd0 || busy !== 1'b1) quiet_ok = 1'b0;
      tick();
    end
    check("fence_seq_quiet", 64'(quiet_ok), 64'd1);
    fence_done = 1'b1;
    tick();
    fence_done = 1'b0;
    check("fence_seq_released", 64'({busy, flush_en}), 64'b10);
    tick();
    check("fence_seq_next_en", 64'(flush_en), 64'd1);
    check("fence_seq_next_pc", flush_pc, 64'h0000_0000_8000_2000);
    tick();
    flush_rdy = 1'b0;
    check("fence_seq_count", 64'(flush_count), 64'd13);
    check("fence_seq_eepoch", 64'(exp_eepoch), 64'd1);
    $display("fence: follow-up driven count=%0d", flush_count);

    // sfence completing on the 16th wait cycle is a success.
    flush_rdy = 1'b1;
    push(64'h0000_0000_8000_3000, 1'b0, 1'b1, 8'd0);
    wait_en(20);
    tick();
    flush_rdy = 1'b0;
    repeat (15) tick();
    check("limit_still_waiting", 64'({busy, err_timeout}), 64'b10);
    fence_done = 1'b1;
    tick();
    fence_done = 1'b0;
    check("limit_done_no_err", 64'({busy, err_timeout}), 64'b00);
    check("limit_count", 64'(flush_count), 64'd14);

`ifdef STAGE0_DRV_TIMEOUT_EN
    flush_rdy = 1'b1;
    push(64'h0000_0000_8000_4000, 1'b0, 1'b1, 8'd0);
    wait_en(20);
    tick();
    flush_rdy = 1'b0;
    repeat (15) tick();
    check("timeout_before", 64'({busy, err_timeout}), 64'b10);
    tick();
    check("timeout_fired", 64'({busy, err_timeout}), 64'b01);
    $display("timeout: err_timeout=%0d busy=%0d", err_timeout, busy);
    drive_one("timeout_next", 64'h0000_0000_8000_5000);
    check("timeout_sticky", 64'(err_timeout), 64'd1);
`else
    flush_rdy = 1'b1;
    push(64'h0000_0000_8000_4000, 1'b0, 1'b1, 8'd0);
    wait_en(20);
    tick();
    flush_rdy = 1'b0;
    repeat (40) tick();
    check("nowatchdog_waiting", 64'({busy, err_timeout}), 64'b10);
    fence_done = 1'b1;
    tick();
    fence_done = 1'b0;
    check("nowatchdog_released", 64'(busy), 64'd0);
    $display("fence wait without watchdog released by fence_done");
    drive_one("nowatchdog_next", 64'h0000_0000_8000_5000);
    check("nowatchdog_err", 64'(err_timeout), 64'd0);
`endif
    check("post_wait_count", 64'(flush_count), 64'd16);
    check("post_wait_eepoch", 64'(exp_eepoch), 64'd0);

    // Reset while driving with two commands still queued.
    flush_rdy = 1'b0;
    push(64'h0000_0000_0000_00a0, 1'b0, 1'b0, 8'd0);
    push(64'h0000_0000_0000_00b0, 1'b0, 1'b0, 8'd0);
    push(64'h0000_0000_0000_00c0, 1'b0, 1'b0, 8'd0);
    wait_en(20);
    check("mid_rst_driving", 64'(flush_en), 64'd1);
    RST = 1'b1;
    tick();
    check("mid_rst_en", 64'(flush_en), 64'd0);
    check("mid_rst_pc", flush_pc, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(flush_count), 64'd0);
    check("mid_rst_eepoch_err", 64'({exp_eepoch, err_timeout}), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    RST = 1'b0;
    repeat (5) tick();
    check("mid_rst_discarded", 64'({busy, flush_en}), 64'd0);
    $display("reset: busy=%0d flush_count=%0d", busy, flush_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
